// File: rtl/div4_sched.sv
// rtl/div4_sched.sv - round-robin two-requester job scheduler that shifts each word out MSB first
// and reports its remainder mod 4 from the last two serial bits.
module div4_sched #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] data0,
  input  logic         req1,
  input  logic [W-1:0] data1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         ser_en,
  output logic         ser_bit,
  output logic         done,
  output logic         div4,
  output logic [1:0]   rem,
  output logic         src
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sr_q, sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     res_q, res_d;
  logic [1:0]     rem_q, rem_d;
  logic           div4_q, div4_d;
  logic           src_q, src_d;
  logic           last_q, last_d;
  logic           gnt0_q, gnt0_d;
  logic           gnt1_q, gnt1_d;
  logic           win0, win1;

  // On a tie the requester that was not served last wins.
  assign win0 = req0 & (~req1 | last_q);
  assign win1 = req1 & (~req0 | ~last_q);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rem_d   = rem_q;
    div4_d  = div4_q;
    src_d   = src_q;
    last_d  = last_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = SHIFT;
          sr_d    = win0 ? data0 : data1;
          src_d   = win1;
          last_d  = win1;
          cnt_d   = '0;
          res_d   = 2'b00;
          gnt0_d  = win0;
          gnt1_d  = win1;
        end
      end
      SHIFT: begin
        sr_d  = {sr_q[W-2:0], 1'b0};
        res_d = {res_q[0], sr_q[W-1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // The last two bits shifted out are the value mod 4.
        rem_d   = res_q;
        div4_d  = (res_q == 2'b00);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      res_q   <= 2'b00;
      rem_q   <= 2'b00;
      div4_q  <= 1'b0;
      src_q   <= 1'b0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      div4_q  <= div4_d;
      src_q   <= src_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = (state_q != IDLE);
  assign ser_en  = (state_q == SHIFT);
  assign ser_bit = (state_q == SHIFT) & sr_q[W-1];
  assign done    = (state_q == DONE);
  assign div4    = div4_q;
  assign rem     = rem_q;
  assign src     = src_q;

endmodule

// File: tb/tb_div4_sched.sv
// tb/tb_div4_sched.sv - directed and randomized bench for div4_sched against a job-level model.
module tb_div4_sched;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] data0 = '0;
  logic [W-1:0] data1 = '0;
  logic         gnt0, gnt1, busy, ser_en, ser_bit, done, div4, src;
  logic [1:0]   rem;

  int checks = 0;
  int failures = 0;
  int last_served = 1;

  div4_sched #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .ser_en(ser_en), .ser_bit(ser_bit),
    .done(done), .div4(div4), .rem(rem), .src(src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run one job from the IDLE cycle; model picks winner and result from the word's value.
  task automatic run_job(input int mode, input bit hold, output int done_t);
    int win;
    int waited;
    logic [W-1:0] w;
    done_t = 0;
    win = (req0 && req1) ? ((last_served == 1) ? 0 : 1) : (req1 ? 1 : 0);
    w = win ? data1 : data0;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!(gnt0 || gnt1) && waited < 20);
    chk("gnt_latency", waited, 1);
    if (!(gnt0 || gnt1)) return;
    last_served = win;
    chk("gnt0", gnt0, win == 0);
    chk("gnt1", gnt1, win == 1);
    chk("src", src, win);
    if (!hold) begin
      if (win == 1) req1 = 1'b0;
      else req0 = 1'b0;
    end
    for (int i = 0; i < W; i++) begin
      chk("ser_en", ser_en, 1);
      chk("ser_bit", ser_bit, w[W-1-i]);
      chk("busy", busy, 1);
      if (i > 0) chk("gnt_pulse", gnt0 | gnt1, 0);
      if (mode == 1 && i == 3) data0 = '1;
      if (mode == 2 && i == 2) req0 = 1'b1;
      if (mode == 2 && i == 3) req0 = 1'b0;
      if (i != W - 1) tick();
    end
    tick();
    chk("done", done, 1);
    chk("ser_en_done", ser_en, 0);
    chk("ser_bit_done", ser_bit, 0);
    done_t = int'($time);
    tick();
    chk("done_pulse", done, 0);
    chk("rem", rem, w % 4);
    chk("div4", div4, (w % 4) == 0);
    chk("src_hold", src, win);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int t1, t2, t3;

    #2 rst = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_ser", {ser_en, ser_bit}, 0);
    chk("rst_done", done, 0);
    chk("rst_res", {div4, rem, src}, 0);
    rst = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Single requester 0, 0x2C -> divisible by 4
    req0 = 1'b1; data0 = 8'h2C;
    run_job(0, 0, t1);
    chk("j2c_div4", div4, 1);
    chk("j2c_rem", rem, 0);

    // Single requester 1, 0x2D -> rem 1
    req1 = 1'b1; data1 = 8'h2D;
    run_job(0, 0, t1);
    chk("j2d_rem", rem, 1);
    chk("j2d_src", src, 1);

    // Both held: order 0,1,0
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h10; data1 = 8'h03;
    run_job(0, 1, t1);
    chk("rr_first", src, 0);
    run_job(0, 1, t2);
    chk("rr_second", src, 1);
    chk("rr_rem3", rem, 3);
    run_job(0, 1, t3);
    chk("rr_third", src, 0);
    chk("done_gap1", t2 - t1, (W + 2) * 10);
    chk("done_gap2", t3 - t2, (W + 2) * 10);
    req0 = 1'b0; req1 = 1'b0;

    // data0 changed mid-shift has no effect
    req0 = 1'b1; data0 = 8'h04;
    run_job(1, 0, t1);
    chk("midchg_div4", div4, 1);
    chk("midchg_rem", rem, 0);

    // Reset during SHIFT cycle 4
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h55; data1 = 8'hA6;
    tick();
    chk("pre_rst_gnt1", gnt1, (last_served == 0) ? 1 : 0);
    tick(); tick(); tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ser", {ser_en, ser_bit}, 0);
    chk("arst_gnt_done", {gnt0, gnt1, done}, 0);
    chk("arst_res", {div4, rem, src}, 0);
    tick();
    chk("arst_nodone", done, 0);
    rst = 1'b1;
    last_served = 1;
    run_job(0, 0, t1);
    chk("post_rst_winner", src, 0);
    req1 = 1'b0;
    tick(); tick();
    chk("dropped_no_gnt", {gnt0, gnt1, busy}, 0);

    // req0 pulsed during a requester-1 job is never granted
    req1 = 1'b1; data1 = 8'h6E;
    run_job(2, 0, t1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pulse_no_gnt0", gnt0, 0);
      chk("pulse_busy", busy, 0);
    end

    // Randomized jobs with a lingering loser
    for (int k = 0; k < 24; k++) begin
      if (!req0 && $urandom_range(0, 1) == 1) begin
        req0 = 1'b1; data0 = W'($urandom);
      end
      if (!req1 && $urandom_range(0, 1) == 1) begin
        req1 = 1'b1; data1 = W'($urandom);
      end
      if (!req0 && !req1) begin
        req0 = 1'b1; data0 = W'($urandom);
      end
      run_job(0, 0, t1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
